// File: rtl/mac_accum16_pkg.sv
// Shared widths, defaults and pipeline-stage records for the mac_accum16 MAC front end.
package mac_accum16_pkg;

  localparam int MAC_OP_W      = 16;
  localparam int MAC_PROD_W    = 32;
  localparam int MAC_ACC_W_DEF = 40;
  localparam int MAC_CNT_W_DEF = 16;

  // S1: registered operand pair feeding the combinational multiplier
  typedef struct packed {
    logic signed [MAC_OP_W-1:0] mcand;
    logic signed [MAC_OP_W-1:0] mplier;
    logic                       last;
  } s1_t;

  // S2: registered full-width product
  typedef struct packed {
    logic signed [MAC_PROD_W-1:0] prod;
    logic                         last;
  } s2_t;

  // Two's-complement add overflow from the sign bits of both addends and the sum
  function automatic logic sgn_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/mac_accum16_if.sv
// Operand and result streams of mac_accum16; slave is the MAC side, master is the producer/consumer.
interface mac_accum16_if
  import mac_accum16_pkg::*;
#(
  parameter int ACC_W = MAC_ACC_W_DEF,
  parameter int CNT_W = MAC_CNT_W_DEF
);

  logic                       in_valid;
  logic                       in_ready;
  logic signed [MAC_OP_W-1:0] in_mcand;
  logic signed [MAC_OP_W-1:0] in_mplier;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_W-1:0]    out_data;
  logic [CNT_W-1:0]           out_count;
  logic                       out_ovf;

  modport master (
    output in_valid, in_mcand, in_mplier, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_mcand, in_mplier, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_ovf
  );

endinterface

// File: rtl/mac_acc_stage.sv
// S3: accumulator, term counter and sticky overflow, plus the held result register for the output stream.
module mac_acc_stage
  import mac_accum16_pkg::*;
#(
  parameter int ACC_W = MAC_ACC_W_DEF,
  parameter int CNT_W = MAC_CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic                         vld_i,
  input  logic                         last_i,
  input  logic signed [MAC_PROD_W-1:0] prod_i,
  output logic                         out_valid_o,
  output logic signed [ACC_W-1:0]      out_data_o,
  output logic [CNT_W-1:0]             out_count_o,
  output logic                         out_ovf_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d, addend, sum;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                    ovf_q, ovf_d, add_ovf;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;
  logic                    out_ovf_q, out_ovf_d;

  assign addend  = ACC_W'(prod_i);
  assign sum     = acc_q + addend;
  assign add_ovf = sgn_ovf(acc_q[ACC_W-1], addend[ACC_W-1], sum[ACC_W-1]);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (en_i) begin
      // en implies any pending result is being taken, so valid only survives via a new last
      out_valid_d = vld_i && last_i;
      if (vld_i) begin
        if (last_i) begin
          out_data_d  = sum;
          out_count_d = cnt_inc;
          out_ovf_d   = ovf_q | add_ovf;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_count_o = out_count_q;
  assign out_ovf_o   = out_ovf_q;

endmodule

// File: rtl/mplier16x16.sv
// Combinational signed 16x16 multiplier; the 32-bit result holds every product, including -32768*-32768.
module mplier16x16
  import mac_accum16_pkg::*;
(
  input  logic signed [MAC_OP_W-1:0]   mcand_i,
  input  logic signed [MAC_OP_W-1:0]   mplier_i,
  output logic signed [MAC_PROD_W-1:0] prod_o
);

  assign prod_o = MAC_PROD_W'(mcand_i) * MAC_PROD_W'(mplier_i);

endmodule

// File: rtl/mac_accum16.sv
// Pipelined signed 16x16 MAC: S1 operand regs, S2 product reg, S3 accumulate; one global stall on output backpressure.
module mac_accum16
  import mac_accum16_pkg::*;
#(
  parameter int ACC_W = MAC_ACC_W_DEF,
  parameter int CNT_W = MAC_CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  mac_accum16_if.slave io
);

  logic                         en, accept;
  logic [1:0]                   vld_pipe_q, vld_pipe_d;
  s1_t                          s1_q, s1_d;
  s2_t                          s2_q, s2_d;
  logic signed [MAC_PROD_W-1:0] prod;

  // Whole pipe freezes, bubbles included, while a result waits on the consumer
  assign en          = !(io.out_valid && !io.out_ready);
  assign io.in_ready = !rst && en;
  assign accept      = io.in_valid && io.in_ready;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[0], accept};
      s2_d       = '{prod: prod, last: s1_q.last};
      if (accept)
        s1_d = '{mcand: io.in_mcand, mplier: io.in_mplier, last: io.in_last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  mplier16x16 u_mul (
    .mcand_i  (s1_q.mcand),
    .mplier_i (s1_q.mplier),
    .prod_o   (prod)
  );

  mac_acc_stage #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .vld_i       (vld_pipe_q[1]),
    .last_i      (s2_q.last),
    .prod_i      (s2_q.prod),
    .out_valid_o (io.out_valid),
    .out_data_o  (io.out_data),
    .out_count_o (io.out_count),
    .out_ovf_o   (io.out_ovf)
  );

endmodule

// File: tb/tb_mac_accum16.sv
// Directed bench for mac_accum16: a 40-bit and a 33-bit instance run in lockstep on the same streams.
module tb_mac_accum16;
  import mac_accum16_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic signed [15:0] in_mcand = '0;
  logic signed [15:0] in_mplier = '0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_accum16_if #(.ACC_W(40), .CNT_W(16)) bus ();
  mac_accum16_if #(.ACC_W(33), .CNT_W(16)) bus33 ();

  assign bus.in_valid    = in_valid;
  assign bus.in_mcand    = in_mcand;
  assign bus.in_mplier   = in_mplier;
  assign bus.in_last     = in_last;
  assign bus.out_ready   = out_ready;
  assign bus33.in_valid  = in_valid;
  assign bus33.in_mcand  = in_mcand;
  assign bus33.in_mplier = in_mplier;
  assign bus33.in_last   = in_last;
  assign bus33.out_ready = out_ready;

  mac_accum16 #(.ACC_W(40), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .io(bus));
  mac_accum16 #(.ACC_W(33), .CNT_W(16)) dut33 (.clk(clk), .rst(rst), .io(bus33));

  typedef struct { logic signed [39:0] data; logic [15:0] cnt; logic ovf; int cyc; } res_t;
  typedef struct { logic signed [32:0] data; logic [15:0] cnt; logic ovf; } res33_t;
  res_t   q[$];
  res33_t q33[$];

  // Record every completed output handshake of both instances
  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_valid && bus.out_ready)
      q.push_back('{bus.out_data, bus.out_count, bus.out_ovf, cyc});
    if (!rst && bus33.out_valid && bus33.out_ready)
      q33.push_back('{bus33.out_data, bus33.out_count, bus33.out_ovf});
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b, input logic l);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_mcand = a; in_mplier = b; in_last = l;
    #1;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 50) begin
      tot_cnt++;
      $display("FAIL send_timeout in_ready=%0b required 1", bus.in_ready);
    end
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
    end
  endtask

  task automatic wait_res(input int n);
    int t;
    t = 0;
    while (q.size() < n && t < 60) begin
      @(negedge clk); #3; t++;
    end
    if (q.size() < n) begin
      tot_cnt++;
      $display("FAIL wait_res got %0d results required %0d", q.size(), n);
    end
  endtask

  task automatic pop(output res_t r);
    if (q.size() > 0) r = q.pop_front();
    else r = '{data: '0, cnt: '0, ovf: 1'b0, cyc: 0};
  endtask

  task automatic pop33(output res33_t r);
    if (q33.size() > 0) r = q33.pop_front();
    else r = '{data: '0, cnt: '0, ovf: 1'b0};
  endtask

  task automatic test_reset();
    res_t r;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tot_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b want 0", bus.out_valid); else pass_cnt++;
    tot_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", bus.in_ready); else pass_cnt++;
    tot_cnt++; if (bus.out_data !== 40'sd0) $display("FAIL rst_out_data got %0d want 0", bus.out_data); else pass_cnt++;
    tot_cnt++; if (bus.out_count !== 16'd0) $display("FAIL rst_out_count got %0d want 0", bus.out_count); else pass_cnt++;
    tot_cnt++; if (bus.out_ovf !== 1'b0) $display("FAIL rst_out_ovf got %0b want 0", bus.out_ovf); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    send(16'sd1, 16'sd1, 1'b0);
    send(16'sd2, 16'sd2, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    tot_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL rst_mid_in_ready got %0b want 0", bus.in_ready); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete(); q33.delete();
    send(16'sd3, 16'sd4, 1'b1);
    idle(1);
    wait_res(1);
    pop(r);
    tot_cnt++; if (r.data !== 40'sd12) $display("FAIL rst_after_data got %0d want 12", r.data); else pass_cnt++;
    tot_cnt++; if (r.cnt !== 16'd1) $display("FAIL rst_after_count got %0d want 1", r.cnt); else pass_cnt++;
    tot_cnt++; if (r.ovf !== 1'b0) $display("FAIL rst_after_ovf got %0b want 0", r.ovf); else pass_cnt++;
  endtask

  task automatic test_basic();
    res_t r;
    int a;
    q.delete(); q33.delete();
    send(16'sd3, 16'sd4, 1'b0);
    send(-16'sd5, 16'sd6, 1'b0);
    send(16'sd7, -16'sd8, 1'b1);
    a = acc_cyc;
    idle(1);
    wait_res(1);
    pop(r);
    tot_cnt++; if (r.data !== -40'sd74) $display("FAIL basic_data got %0d want -74", r.data); else pass_cnt++;
    tot_cnt++; if (r.cnt !== 16'd3) $display("FAIL basic_count got %0d want 3", r.cnt); else pass_cnt++;
    tot_cnt++; if (r.ovf !== 1'b0) $display("FAIL basic_ovf got %0b want 0", r.ovf); else pass_cnt++;
    tot_cnt++; if (r.cyc - a !== 3) $display("FAIL basic_latency got %0d want 3", r.cyc - a); else pass_cnt++;
    idle(5);
    tot_cnt++; if (q.size() !== 0) $display("FAIL basic_pulse extra results %0d want 0", q.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    res_t r0, r1;
    q.delete(); q33.delete();
    send(16'sd2, 16'sd2, 1'b1);
    send(-16'sd1, 16'sd1, 1'b1);
    idle(1);
    wait_res(2);
    pop(r0); pop(r1);
    tot_cnt++; if (r0.data !== 40'sd4) $display("FAIL b2b_data0 got %0d want 4", r0.data); else pass_cnt++;
    tot_cnt++; if (r1.data !== -40'sd1) $display("FAIL b2b_data1 got %0d want -1", r1.data); else pass_cnt++;
    tot_cnt++; if (r0.cnt !== 16'd1) $display("FAIL b2b_count0 got %0d want 1", r0.cnt); else pass_cnt++;
    tot_cnt++; if (r1.cnt !== 16'd1) $display("FAIL b2b_count1 got %0d want 1", r1.cnt); else pass_cnt++;
    tot_cnt++; if (r1.cyc - r0.cyc !== 1) $display("FAIL b2b_spacing got %0d want 1", r1.cyc - r0.cyc); else pass_cnt++;
    idle(3);
  endtask

  task automatic test_backpressure();
    res_t r0, r1;
    q.delete(); q33.delete();
    out_ready = 1'b0;
    send(16'sd5, 16'sd5, 1'b1);
    send(16'sd1, 16'sd2, 1'b0);
    send(16'sd3, 16'sd4, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_mcand = 16'sd10; in_mplier = 16'sd10; in_last = 1'b1;
    #1;
    tot_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid got %0b want 1", bus.out_valid); else pass_cnt++;
    tot_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %0b want 0", bus.in_ready); else pass_cnt++;
    tot_cnt++; if (bus.out_data !== 40'sd25) $display("FAIL bp_data got %0d want 25", bus.out_data); else pass_cnt++;
    repeat (3) begin @(negedge clk); #1; end
    tot_cnt++; if (bus.out_data !== 40'sd25) $display("FAIL bp_data_stable got %0d want 25", bus.out_data); else pass_cnt++;
    tot_cnt++; if (bus.out_count !== 16'd1) $display("FAIL bp_count_stable got %0d want 1", bus.out_count); else pass_cnt++;
    tot_cnt++; if (bus.out_ovf !== 1'b0) $display("FAIL bp_ovf_stable got %0b want 0", bus.out_ovf); else pass_cnt++;
    tot_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_held got %0b want 0", bus.in_ready); else pass_cnt++;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    tot_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %0b want 1", bus.in_ready); else pass_cnt++;
    @(posedge clk);
    idle(1);
    wait_res(2);
    pop(r0); pop(r1);
    tot_cnt++; if (r0.data !== 40'sd25 || r0.cnt !== 16'd1) $display("FAIL bp_res0 got %0d/%0d want 25/1", r0.data, r0.cnt); else pass_cnt++;
    tot_cnt++; if (r1.data !== 40'sd114) $display("FAIL bp_res1_data got %0d want 114", r1.data); else pass_cnt++;
    tot_cnt++; if (r1.cnt !== 16'd3) $display("FAIL bp_res1_count got %0d want 3", r1.cnt); else pass_cnt++;
    idle(3);
  endtask

  task automatic test_extreme();
    res_t   r;
    res33_t s;
    q.delete(); q33.delete();
    send(-16'sd32768, -16'sd32768, 1'b1);
    idle(1); wait_res(1); pop(r); pop33(s);
    tot_cnt++; if (r.data !== 40'sd1073741824) $display("FAIL ext1_data got %0d want 1073741824", r.data); else pass_cnt++;
    tot_cnt++; if (r.cnt !== 16'd1 || r.ovf !== 1'b0) $display("FAIL ext1_cnt_ovf got %0d/%0b want 1/0", r.cnt, r.ovf); else pass_cnt++;
    // three terms still fit in 33 bits
    repeat (2) send(-16'sd32768, -16'sd32768, 1'b0);
    send(-16'sd32768, -16'sd32768, 1'b1);
    idle(1); wait_res(1); pop(r); pop33(s);
    tot_cnt++; if (r.data !== 40'sd3221225472) $display("FAIL ext3_data40 got %0d want 3221225472", r.data); else pass_cnt++;
    tot_cnt++; if (s.data !== 33'h0_C000_0000 || s.ovf !== 1'b0) $display("FAIL ext3_33 got %0h/%0b want c0000000/0", s.data, s.ovf); else pass_cnt++;
    repeat (3) send(-16'sd32768, -16'sd32768, 1'b0);
    send(-16'sd32768, -16'sd32768, 1'b1);
    idle(1); wait_res(1); pop(r); pop33(s);
    tot_cnt++; if (r.data !== 40'sd4294967296 || r.ovf !== 1'b0) $display("FAIL ext4_40 got %0d/%0b want 4294967296/0", r.data, r.ovf); else pass_cnt++;
    tot_cnt++; if (s.data !== 33'h1_0000_0000) $display("FAIL ext4_33_data got %0h want 100000000", s.data); else pass_cnt++;
    tot_cnt++; if (s.ovf !== 1'b1) $display("FAIL ext4_33_ovf got %0b want 1", s.ovf); else pass_cnt++;
    tot_cnt++; if (s.cnt !== 16'd4) $display("FAIL ext4_33_count got %0d want 4", s.cnt); else pass_cnt++;
    repeat (4) send(-16'sd32768, -16'sd32768, 1'b0);
    send(-16'sd32768, -16'sd32768, 1'b1);
    idle(1); wait_res(1); pop(r); pop33(s);
    tot_cnt++; if (s.data !== 33'h1_4000_0000 || s.ovf !== 1'b1) $display("FAIL ext5_33_sticky got %0h/%0b want 140000000/1", s.data, s.ovf); else pass_cnt++;
    send(16'sd1, 16'sd1, 1'b1);
    idle(1); wait_res(1); pop(r); pop33(s);
    tot_cnt++; if (s.data !== 33'h0_0000_0001 || s.ovf !== 1'b0) $display("FAIL ext_clear_33 got %0h/%0b want 1/0", s.data, s.ovf); else pass_cnt++;
    idle(2);
  endtask

  task automatic test_bubbles();
    res_t r;
    for (int run = 0; run < 3; run++) begin
      q.delete(); q33.delete();
      send(16'sd3, 16'sd4, 1'b0);
      idle($urandom_range(0, 3));
      send(-16'sd5, 16'sd6, 1'b0);
      idle($urandom_range(0, 3));
      send(16'sd7, -16'sd8, 1'b1);
      idle(1);
      wait_res(1);
      pop(r);
      tot_cnt++; if (r.data !== -40'sd74) $display("FAIL bubble_data run%0d got %0d want -74", run, r.data); else pass_cnt++;
      tot_cnt++; if (r.cnt !== 16'd3) $display("FAIL bubble_count run%0d got %0d want 3", run, r.cnt); else pass_cnt++;
      idle(2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_extreme();
    test_bubbles();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
